measurement_averager: RTL and testbench

//  Downstream of the measurement counter / state machine: takes each completed conversion
//  (12-bit count + reference sign), converts to signed, averages 2**AVG_LOG2 conversions,

---
 rtl/measurement_averager_pkg.sv | 13 +
 rtl/measurement_averager.sv | 94 +++++++++
 tb/tb_measurement_averager.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/measurement_averager_pkg.sv
// Shared voltmeter definitions: measurement width, reference-sign encoding
// and the averager output-state enum.
package measurement_averager_pkg;

    localparam int   DEFAULT_COUNT_W = 12;
    localparam logic REF_SIGN_NEG    = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/measurement_averager.sv
// Averages 2**AVG_LOG2 signed conversions and holds each result behind a
// valid/ready handshake. Conversions are never stalled; unread results are overwritten.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  EMPTY | no unread result; result_valid_o low
//  FULL  | result_o holds an unread average; result_valid_o high
module measurement_averager
    import measurement_averager_pkg::*;
#(
    parameter int COUNT_W  = DEFAULT_COUNT_W,
    parameter int AVG_LOG2 = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               sample_valid_i,
    input  logic [COUNT_W-1:0] sample_count_i,
    input  logic               sample_sign_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [COUNT_W:0]   result_o,
    output logic               overrun_o,
    output logic [AVG_LOG2:0]  sample_idx_o
);

    localparam int ACC_W = COUNT_W + 1 + AVG_LOG2;
    localparam int RES_W = COUNT_W + 1;
    localparam int IDX_W = AVG_LOG2 + 1;
    localparam int N     = 1 << AVG_LOG2;

    out_state_t              state, state_next;
    logic signed [ACC_W-1:0] acc;
    logic signed [RES_W-1:0] s;
    logic signed [ACC_W-1:0] s_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [RES_W-1:0] result_next;
    logic                    window_end;
    logic                    overrun_set;

    always_comb begin
        // Negating a zero magnitude yields zero, so there is no negative zero.
        s = sample_sign_i == REF_SIGN_NEG ? -$signed({1'b0, sample_count_i})
                                          :  $signed({1'b0, sample_count_i});
        s_ext       = ACC_W'(s);
        sum         = acc + s_ext;
        result_next = RES_W'(sum >>> AVG_LOG2);
        window_end  = sample_valid_i && !clear_i && (sample_idx_o == IDX_W'(N - 1));
    end

    always_comb begin
        state_next  = state;
        overrun_set = 1'b0;
        case (state)
            EMPTY: begin
                if (window_end) state_next = FULL;
            end
            FULL: begin
                if (window_end) begin
                    overrun_set = !result_ready_i;
                end else if (result_ready_i) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state        <= EMPTY;
            acc          <= '0;
            sample_idx_o <= '0;
            result_o     <= '0;
            overrun_o    <= 1'b0;
        end else begin
            state <= state_next;
            if (sample_valid_i) begin
                if (window_end) begin
                    acc          <= '0;
                    sample_idx_o <= '0;
                    result_o     <= result_next;
                end else begin
                    acc          <= sum;
                    sample_idx_o <= sample_idx_o + IDX_W'(1);
                end
            end
            if (overrun_set) overrun_o <= 1'b1;
        end
    end

    assign result_valid_o = (state == FULL);

endmodule

// File: tb/tb_measurement_averager.sv
// Directed bench for measurement_averager at COUNT_W=12, AVG_LOG2=2.
module tb_measurement_averager;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        sample_valid_i = 1'b0;
    logic [11:0] sample_count_i = '0;
    logic        sample_sign_i = 1'b0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [12:0] result_o;
    logic        overrun_o;
    logic [2:0]  sample_idx_o;

    int n_checks = 0;
    int n_pass   = 0;

    measurement_averager #(.COUNT_W(12), .AVG_LOG2(2)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .sample_valid_i (sample_valid_i),
        .sample_count_i (sample_count_i),
        .sample_sign_i  (sample_sign_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .overrun_o      (overrun_o),
        .sample_idx_o   (sample_idx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic neg, input int count);
        sample_valid_i = 1'b1;
        sample_sign_i  = neg;
        sample_count_i = 12'(count);
        tick();
        sample_valid_i = 1'b0;
        sample_sign_i  = 1'b0;
        sample_count_i = '0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int res();
        return int'($signed(result_o));
    endfunction

    initial begin
        // Reset
        tick(); tick();
        rst_i = 1'b0;
        chk("reset_valid",   int'(result_valid_o), 0);
        chk("reset_result",  res(), 0);
        chk("reset_overrun", int'(overrun_o), 0);
        chk("reset_idx",     int'(sample_idx_o), 0);

        // Reset mid-window
        result_ready_i = 1'b1;
        send(0, 7); send(0, 7);
        chk("mid_idx", int'(sample_idx_o), 2);
        rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
        chk("mid_rst_idx",   int'(sample_idx_o), 0);
        chk("mid_rst_valid", int'(result_valid_o), 0);
        chk("mid_rst_res",   res(), 0);

        // Basic average
        send(0, 100); send(0, 200); send(0, 300);
        chk("avg_idx3",   int'(sample_idx_o), 3);
        chk("avg_pre_v",  int'(result_valid_o), 0);
        send(0, 400);
        chk("avg_valid",  int'(result_valid_o), 1);
        chk("avg_result", res(), 250);
        chk("avg_idx0",   int'(sample_idx_o), 0);
        tick();
        chk("avg_consumed", int'(result_valid_o), 0);
        chk("avg_hold",     res(), 250);

        // Floor toward -inf and no negative zero
        send(1, 1); send(1, 1); send(1, 1); send(1, 0);
        chk("floor_result", res(), -1);
        chk("floor_valid",  int'(result_valid_o), 1);

        // Extremes
        tick();
        send(1, 4095); send(1, 4095); send(1, 4095); send(1, 4095);
        chk("ext_neg", res(), -4095);
        send(0, 4095); send(0, 4095); send(0, 4095); send(0, 4095);
        chk("ext_pos", res(), 4095);
        tick();
        chk("ext_consumed", int'(result_valid_o), 0);

        // Overrun
        result_ready_i = 1'b0;
        repeat (4) send(0, 10);
        chk("ovr_first",   res(), 10);
        chk("ovr_first_o", int'(overrun_o), 0);
        tick();
        chk("ovr_hold_v",  int'(result_valid_o), 1);
        chk("ovr_hold_r",  res(), 10);
        repeat (4) send(0, 20);
        chk("ovr_result",  res(), 20);
        chk("ovr_flag",    int'(overrun_o), 1);
        chk("ovr_valid",   int'(result_valid_o), 1);
        result_ready_i = 1'b1; tick(); result_ready_i = 1'b0;
        chk("ovr_read_v",  int'(result_valid_o), 0);
        chk("ovr_sticky",  int'(overrun_o), 1);
        tick();
        chk("ovr_sticky2", int'(overrun_o), 1);
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        chk("ovr_cleared", int'(overrun_o), 0);

        // Window end coincident with valid&ready
        repeat (4) send(0, 8);
        chk("sim_a",       res(), 8);
        repeat (3) send(0, 16);
        chk("sim_hold",    res(), 8);
        result_ready_i = 1'b1;
        send(0, 16);
        result_ready_i = 1'b0;
        chk("sim_result",  res(), 16);
        chk("sim_valid",   int'(result_valid_o), 1);
        chk("sim_overrun", int'(overrun_o), 0);

        // Clear coincident with a sample
        send(0, 1); send(0, 1);
        chk("clr_pre_idx", int'(sample_idx_o), 2);
        clear_i = 1'b1;
        send(0, 999);
        clear_i = 1'b0;
        chk("clr_idx",   int'(sample_idx_o), 0);
        chk("clr_valid", int'(result_valid_o), 0);
        chk("clr_res",   res(), 0);
        repeat (3) send(0, 40);
        chk("clr_win_pre", int'(result_valid_o), 0);
        send(0, 40);
        chk("clr_win",   res(), 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
